// File: rtl/oled_spi_arbiter_if.sv
// oled_spi_arbiter_if: requester and spi_master handshakes around the OLED SPI arbiter.
// OLED_ARB_WATCHDOG_EN adds timeout_err/err_clr.
interface oled_spi_arbiter_if #(
  parameter int WORD_LEN = 8
);
  logic                cmd_req, cmd_ack, cmd_done;
  logic                dat_req, dat_lock, dat_ack, dat_done;
  logic                spi_wr, spi_done, oled_dc, busy;
  logic [WORD_LEN-1:0] cmd_byte, dat_byte, spi_data;
`ifdef OLED_ARB_WATCHDOG_EN
  logic                timeout_err, err_clr;
`endif
  modport slave (
`ifdef OLED_ARB_WATCHDOG_EN
    input err_clr, output timeout_err,
`endif
    input cmd_req, cmd_byte, dat_req, dat_byte, dat_lock, spi_done,
    output cmd_ack, cmd_done, dat_ack, dat_done, spi_data, spi_wr, oled_dc, busy
  );
  modport master (
`ifdef OLED_ARB_WATCHDOG_EN
    output err_clr, input timeout_err,
`endif
    output cmd_req, cmd_byte, dat_req, dat_byte, dat_lock, spi_done,
    input cmd_ack, cmd_done, dat_ack, dat_done, spi_data, spi_wr, oled_dc, busy
  );
endinterface

// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter: grants spi_master one byte at a time to command (D/C=0) or pixel (D/C=1) requester.
// OLED_ARB_WATCHDOG_EN adds a WAIT-state timeout with sticky timeout_err.
module oled_spi_arbiter #(
  parameter int DC_SETUP  = 2,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 4096
) (
  input logic               clk,
  input logic               rst,
  oled_spi_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(TIMEOUT > 16 ? TIMEOUT : 16) + 1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, WAIT} state_t;
  state_t          state, state_nxt;
  logic            owner, lock_ok, grant_cmd, grant_dat, timeout;
  logic [BW-1:0]   burst_cnt;
  logic [CW-1:0]   cnt;
  always_comb begin
    lock_ok   = owner && bus.dat_lock && bus.dat_req && burst_cnt < BW'(MAX_BURST);
    // acks are combinational, so they are gated by reset to stay low while it is asserted
    grant_cmd = rst && state == IDLE && bus.cmd_req && !lock_ok;
    grant_dat = rst && state == IDLE && bus.dat_req && (lock_ok || !bus.cmd_req);
`ifdef OLED_ARB_WATCHDOG_EN
    timeout   = state == WAIT && !bus.spi_done && cnt == CW'(TIMEOUT - 1);
`else
    timeout   = 1'b0;
`endif
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !(grant_cmd || grant_dat) ? IDLE : grant_dat != bus.oled_dc ? SETUP : STROBE;
      SETUP:   state_nxt = cnt == CW'(DC_SETUP - 1) ? STROBE : SETUP;
      STROBE:  state_nxt = WAIT;
      WAIT:    state_nxt = bus.spi_done || timeout ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
    bus.cmd_ack  = grant_cmd;
    bus.dat_ack  = grant_dat;
    bus.spi_wr   = state == STROBE;
    bus.cmd_done = state == WAIT && bus.spi_done && !owner;
    bus.dat_done = state == WAIT && bus.spi_done && owner;
    bus.busy     = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= IDLE;
      owner           <= 1'b0;
      burst_cnt       <= '0;
      cnt             <= '0;
      bus.oled_dc     <= 1'b0;
      bus.spi_data    <= '0;
`ifdef OLED_ARB_WATCHDOG_EN
      bus.timeout_err <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= state_nxt == state ? cnt + 1'b1 : '0;
      burst_cnt <= grant_cmd || !bus.dat_lock ? '0 : grant_dat && bus.cmd_req ? burst_cnt + 1'b1 : burst_cnt;
      if (grant_cmd || grant_dat) begin
        owner        <= grant_dat;
        bus.oled_dc  <= grant_dat;
        bus.spi_data <= grant_dat ? bus.dat_byte : bus.cmd_byte;
      end
`ifdef OLED_ARB_WATCHDOG_EN
      bus.timeout_err <= timeout || (bus.timeout_err && !bus.err_clr);
`endif
    end
endmodule
